program_loader: RTL and testbench
=================================

# program_loader

Stream-in program loader and run controller for the MIPS CPU. It takes the program image as a byte stream, assembles big-endian 32-bit words and writes them into instruction memory while holding the CPU in reset. It then releases reset for a fixed cycle budget plus pipeline drain cycles, and re-asserts reset when the budget expires. It is the driving end of the CPU's clock/reset/program interface and replaces file-preloaded instruction memory in hardware builds.

## Interface
Parameters:
- ADDR_WIDTH, 10, IM word-address width; capacity is 2^ADDR_WIDTH words.
- DRAIN_CYCLES, 5, extra cycles after the budget so in-flight instructions finish the pipeline.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte available on in_data.
- in_ready  out  1  loader accepts a byte; a transfer is in_valid & in_ready at a rising edge.
- in_data  in  8  program byte, most significant byte of each word first.
- in_last  in  1  qualifies the final byte of the image.
- run_cycles  in  32  instruction budget; sampled on the edge that accepts the last byte.
- im_we  out  1  IM write strobe, one cycle per word.
- im_addr  out  ADDR_WIDTH  IM word address.
- im_wdata  out  32  IM write data.
- cpu_reset  out  1  active-high CPU reset.
- busy  out  1  high while the CPU runs.
- done  out  1  sticky; the run completed.
- error  out  1  sticky; the image was malformed.
- word_count  out  ADDR_WIDTH+1  number of words written.

## Operation
- States: LOAD, RELEASE, RUN, DONE, ERROR.
- LOAD: in_ready=1 and cpu_reset=1.
  - Each transfer shifts in_data into a 32-bit assembly register (MSB first) and increments byte_idx (0..3).
  - The transfer with byte_idx=3 registers im_we=1, im_addr=word_count[ADDR_WIDTH-1:0] and im_wdata=the assembled word, increments word_count and sets byte_idx=0.
  - in_last on that same transfer latches run_cycles and goes to RELEASE.
  - in_last with byte_idx≠3 goes to ERROR; the partial word is not written.
  - A transfer while word_count==2^ADDR_WIDTH goes to ERROR.
- RELEASE: in_ready=0. The last im_we is visible this cycle. On the next edge: im_we=0, cpu_reset=0, busy=1, cycle counter=0, go to RUN.
- RUN: in_ready=0 and cpu_reset=0. The 33-bit counter increments every cycle. When counter==latched run_cycles+DRAIN_CYCLES (33-bit sum, no overflow), the next edge sets cpu_reset=1, busy=0, done=1 and goes to DONE.
- DONE: in_ready=0 and cpu_reset=1; held until reset. Further in_valid is ignored.
- ERROR: in_ready=0, cpu_reset=1, error=1; held until reset. The CPU never runs.
- im_we is 0 outside the registered write cycle. im_addr and im_wdata hold their last values.

## Timing
- Reset values: state=LOAD, in_ready=1, cpu_reset=1, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, error=0, word_count=0, byte_idx=0.
- Write latency: the 4th byte is accepted at edge N, and im_we is high during cycle N→N+1 only. Back-to-back words therefore write on consecutive 4-cycle boundaries at full rate.
- Release: the last byte is accepted at edge N, im_we is high during N→N+1, and cpu_reset falls at edge N+1. The CPU never fetches before the final write.
- Run length: cpu_reset stays low for exactly run_cycles+DRAIN_CYCLES+1 rising edges, then rises.
- run_cycles=0: the CPU still runs DRAIN_CYCLES+1 cycles.
- Asynchronous reset mid-LOAD or mid-RUN: immediate return to reset values, cpu_reset=1, and any partial word is discarded. IM contents are not cleared; the next load overwrites from address 0.
- in_last without in_valid has no effect.

## Test plan
- Load 3 words, bytes 00 00 00 01 / 20 08 00 05 / AC 01 00 00 with in_last on byte 12, run_cycles=3 -> im_we pulses at addresses 0,1,2 with data 00000001, 20080005, AC010000; word_count=3. cpu_reset falls one edge after the last write, stays low 9 edges, then done=1, busy=0.
- Same image with in_valid toggling every other cycle -> identical IM writes and identical run length.
- in_last on the 6th byte -> one write (addr 0), then error=1, cpu_reset stays 1, in_ready=0, no second write.
- ADDR_WIDTH=2: 4 full words followed by one more byte -> 4 writes, then error=1 on the 17th transfer.
- Assert reset in RUN after 2 cycles -> cpu_reset=1 and state LOAD immediately. A reload of 1 word with run_cycles=0 -> write at addr 0, then 6 run cycles, then done=1.
- run_cycles=FFFFFFFF -> no wrap; busy stays high for at least 2^16 checked cycles and done stays 0.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: streams a big-endian byte image into IM while holding the CPU in reset, then runs it for a fixed budget.
// Ports: clk/reset (async active-low); in_valid/in_ready/in_data/in_last byte stream; run_cycles budget;
// im_we/im_addr/im_wdata IM write port; cpu_reset/busy/done/error run status; word_count words written.
module program_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  input  logic [31:0]           run_cycles,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);
  typedef enum logic [2:0] {LOAD, RELEASE, RUN, DONE, ERROR} state_t;
  state_t                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           asm_q, asm_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  im_we_q, im_we_d;
  logic [ADDR_WIDTH-1:0] im_addr_q, im_addr_d;
  logic [31:0]           im_wdata_q, im_wdata_d;
  logic [31:0]           run_q, run_d;
  logic [32:0]           cnt_q, cnt_d;
  logic                  xfer;
  logic [32:0]           limit;
  assign in_ready   = state_q == LOAD;
  assign xfer       = in_valid & in_ready;
  // 33-bit sum so a budget of all-ones cannot wrap into a short run
  assign limit      = {1'b0, run_q} + 33'(DRAIN_CYCLES);
  assign cpu_reset  = state_q != RUN;
  assign busy       = state_q == RUN;
  assign done       = state_q == DONE;
  assign error      = state_q == ERROR;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign word_count = word_count_q;
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    word_count_d = word_count_q;
    im_we_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    run_d        = run_q;
    cnt_d        = cnt_q;
    case (state_q)
      LOAD: if (xfer) begin
        // the top bit of word_count set means IM is already full
        if (word_count_q[ADDR_WIDTH]) state_d = ERROR;
        else if (byte_idx_q == 2'd3) begin
          im_we_d      = 1'b1;
          im_addr_d    = word_count_q[ADDR_WIDTH-1:0];
          im_wdata_d   = {asm_q, in_data};
          word_count_d = word_count_q + 1'b1;
          byte_idx_d   = 2'd0;
          if (in_last) begin
            run_d   = run_cycles;
            state_d = RELEASE;
          end
        end else if (in_last) state_d = ERROR;
        else begin
          asm_d      = {asm_q[15:0], in_data};
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      RELEASE: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d   = cnt_q + 33'd1;
        state_d = cnt_q == limit ? DONE : RUN;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LOAD;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      word_count_q <= '0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      run_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      word_count_q <= word_count_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      run_q        <= run_d;
      cnt_q        <= cnt_d;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of the loader with default and 2-bit address widths.
module tb_program_loader;
  logic        clk, reset, in_valid, in_last;
  logic [7:0]  in_data;
  logic [31:0] run_cycles;
  logic        in_ready, im_we, cpu_reset, busy, done, error;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [10:0] word_count;
  logic        s_ready, s_we, s_cpu_reset, s_busy, s_done, s_error;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_wc;
  int          nchk, nerr, nw, nw2, base, base2, len;
  logic [9:0]  wa [64];
  logic [31:0] wd [64];
  logic [7:0]  img [12];
  logic        ok;
  program_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .run_cycles(run_cycles), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );
  program_loader #(.ADDR_WIDTH(2)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_ready), .in_data(in_data),
    .in_last(in_last), .run_cycles(run_cycles), .im_we(s_we), .im_addr(s_addr),
    .im_wdata(s_wdata), .cpu_reset(s_cpu_reset), .busy(s_busy), .done(s_done), .error(s_error),
    .word_count(s_wc)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (im_we && nw < 64) begin
      wa[nw] = im_addr;
      wd[nw] = im_wdata;
      nw++;
    end
    if (s_we) nw2++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic l, input logic [31:0] rc);
    in_data = d;
    in_last = l;
    run_cycles = rc;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic do_reset();
    reset = 0;
    @(posedge clk);
    #1;
    reset = 1;
  endtask
  task automatic load_img(input int n, input bit gap, input logic [31:0] rc);
    for (int i = 0; i < n; i++) begin
      send(img[i], i == n - 1, rc);
      if (gap && i < n - 1) begin
        in_last = 1;
        @(posedge clk);
        #1;
        in_last = 0;
      end
    end
  endtask
  task automatic check_run(input string t, input int exp_len);
    int n;
    check({t, "_last_we"}, im_we, 1);
    check({t, "_rel_rst"}, cpu_reset, 1);
    check({t, "_rel_rdy"}, in_ready, 0);
    @(posedge clk);
    #1;
    check({t, "_run_rst"}, cpu_reset, 0);
    check({t, "_run_busy"}, busy, 1);
    check({t, "_run_we"}, im_we, 0);
    n = 0;
    while (cpu_reset === 1'b0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({t, "_len"}, n, exp_len);
    check({t, "_done"}, done, 1);
    check({t, "_busy"}, busy, 0);
    check({t, "_rdy"}, in_ready, 0);
  endtask
  task automatic check_img(input string t);
    check({t, "_nw"}, nw - base, 3);
    check({t, "_wc"}, word_count, 3);
    check({t, "_a0"}, wa[base], 0);
    check({t, "_d0"}, wd[base], 32'h00000001);
    check({t, "_a1"}, wa[base+1], 1);
    check({t, "_d1"}, wd[base+1], 32'h20080005);
    check({t, "_a2"}, wa[base+2], 2);
    check({t, "_d2"}, wd[base+2], 32'hAC010000);
  endtask
  initial begin
    img = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};
    nchk = 0; nerr = 0; nw = 0; nw2 = 0;
    in_valid = 0; in_last = 0; in_data = 0; run_cycles = 0;
    reset = 1;
    #2 reset = 0;
    #10;
    check("rst_rdy", in_ready, 1);
    check("rst_cpu", cpu_reset, 1);
    check("rst_we", im_we, 0);
    check("rst_addr", im_addr, 0);
    check("rst_wdata", im_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    check("rst_wc", word_count, 0);
    @(posedge clk);
    #1;
    reset = 1;
    base = nw;
    load_img(12, 0, 3);
    check("t1_addr", im_addr, 2);
    check("t1_wdata", im_wdata, 32'hAC010000);
    check_run("t1", 9);
    check_img("t1");
    send(8'h55, 0, 0);
    check("t1_ignored_wc", word_count, 3);
    check("t1_ignored_done", done, 1);
    do_reset();
    base = nw;
    load_img(12, 1, 3);
    check_run("tog", 9);
    check_img("tog");
    do_reset();
    base = nw;
    send(8'h11, 0, 0); send(8'h22, 0, 0); send(8'h33, 0, 0);
    send(8'h44, 0, 0); send(8'h55, 0, 0); send(8'h66, 1, 0);
    check("err_flag", error, 1);
    check("err_cpu", cpu_reset, 1);
    check("err_rdy", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("err_nw", nw - base, 1);
    check("err_d0", wd[base], 32'h11223344);
    check("err_wc", word_count, 1);
    check("err_busy", busy, 0);
    do_reset();
    base2 = nw2;
    for (int i = 0; i < 16; i++) send(8'(i), 0, 0);
    check("ovf_pre_err", s_error, 0);
    check("ovf_pre_wc", s_wc, 4);
    send(8'hEE, 0, 0);
    check("ovf_err", s_error, 1);
    check("ovf_rdy", s_ready, 0);
    check("ovf_cpu", s_cpu_reset, 1);
    check("ovf_nw", nw2 - base2, 4);
    check("ovf_big_err", error, 0);
    do_reset();
    load_img(12, 0, 3);
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_pre", busy, 1);
    reset = 0;
    #1;
    check("mid_cpu", cpu_reset, 1);
    check("mid_rdy", in_ready, 1);
    check("mid_busy", busy, 0);
    check("mid_wc", word_count, 0);
    #2 reset = 1;
    send(8'hAA, 0, 0); send(8'hBB, 0, 0);
    reset = 0;
    #1 reset = 1;
    base = nw;
    send(8'hDE, 0, 0); send(8'hAD, 0, 0); send(8'hBE, 0, 0); send(8'hEF, 1, 0);
    check_run("rc0", 6);
    check("rc0_nw", nw - base, 1);
    check("rc0_a0", wa[base], 0);
    check("rc0_d0", wd[base], 32'hDEADBEEF);
    check("rc0_wc", word_count, 1);
    do_reset();
    send(8'h01, 0, 0); send(8'h02, 0, 0); send(8'h03, 0, 0); send(8'h04, 1, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    ok = 1;
    for (int i = 0; i < 65536; i++) begin
      if (!(busy === 1'b1 && done === 1'b0 && cpu_reset === 1'b0)) ok = 0;
      @(posedge clk);
      #1;
    end
    check("long_busy", ok, 1);
    check("long_done", done, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
